mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 40 ++++
 rtl/mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side bus of the byte-serial memory controller.
// Handshake: *_ena is a one-cycle request pulse with its operands valid in the same cycle (no back-pressure,
// a later pulse on the same port replaces a pending one); *_ready is a one-cycle completion pulse whose data is held afterwards.
interface mem_ctrl_if;
    logic        in_if_ena;
    logic [31:0] in_if_addr;
    logic        out_if_ready;
    logic [31:0] out_if_inst;

    logic        in_ls_ena;
    logic        in_ls_write;
    logic [31:0] in_ls_addr;
    logic [1:0]  in_ls_size;
    logic [31:0] in_ls_wdata;
    logic        out_ls_ready;
    logic [31:0] out_ls_rdata;

    logic [7:0]  in_ram_din;
    logic [7:0]  out_ram_dout;
    logic [31:0] out_ram_addr;
    logic        out_ram_wr;

    modport master (
        output in_if_ena, in_if_addr,
        input  out_if_ready, out_if_inst,
        output in_ls_ena, in_ls_write, in_ls_addr, in_ls_size, in_ls_wdata,
        input  out_ls_ready, out_ls_rdata,
        output in_ram_din,
        input  out_ram_dout, out_ram_addr, out_ram_wr
    );

    modport slave (
        input  in_if_ena, in_if_addr,
        output out_if_ready, out_if_inst,
        input  in_ls_ena, in_ls_write, in_ls_addr, in_ls_size, in_ls_wdata,
        output out_ls_ready, out_ls_rdata,
        input  in_ram_din,
        output out_ram_dout, out_ram_addr, out_ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store requests onto an 8-bit RAM.
// dbg_state_o encoding: 0=IDLE, 1=READ, 2=WRITE.
module mem_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_rollback,
    mem_ctrl_if.slave  bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic        is_fetch_q;

    logic        if_pend_q;
    logic [31:0] if_addr_q;
    logic        ls_pend_q;
    logic        ls_write_q;
    logic [31:0] ls_addr_q;
    logic [1:0]  ls_size_q;
    logic [31:0] ls_wdata_q;

    logic        if_ready_q;
    logic        ls_ready_q;
    logic [31:0] if_inst_q;
    logic [31:0] ls_rdata_q;
    logic [31:0] ram_addr_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q;

    logic [2:0]  cnt_d;
    logic [31:0] addr_d;
    logic        start_ls;
    logic        start_if;
    logic        take_if;
    logic        take_ls;

    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign cnt_d  = cnt_q + 3'd1;
    assign addr_d = base_q + {29'd0, cnt_d};

    // Rollback kills pending loads/fetches and any request arriving alongside it; stores survive.
    always_comb begin
        start_ls = ls_pend_q && (ls_write_q || !in_rollback);
        start_if = if_pend_q && !in_rollback && !start_ls;
        take_if  = bus.in_if_ena && !in_rollback;
        take_ls  = bus.in_ls_ena && !in_rollback;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            is_fetch_q <= 1'b0;
            if_pend_q  <= 1'b0;
            if_addr_q  <= 32'd0;
            ls_pend_q  <= 1'b0;
            ls_write_q <= 1'b0;
            ls_addr_q  <= 32'd0;
            ls_size_q  <= 2'd0;
            ls_wdata_q <= 32'd0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_inst_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            ram_addr_q <= 32'd0;
            ram_dout_q <= 8'd0;
            ram_wr_q   <= 1'b0;
        end else if (ena) begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;

            if (in_rollback) begin
                if_pend_q <= 1'b0;
                if (!ls_write_q) begin
                    ls_pend_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_ls) begin
                        state_q    <= ls_write_q ? WRITE : READ;
                        ls_pend_q  <= 1'b0;
                        base_q     <= ls_addr_q;
                        len_q      <= xfer_len(ls_size_q);
                        wdata_q    <= ls_wdata_q;
                        is_fetch_q <= 1'b0;
                        cnt_q      <= 3'd0;
                        rbuf_q     <= 32'd0;
                        ram_addr_q <= ls_addr_q;
                        if (ls_write_q) begin
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= ls_wdata_q[7:0];
                        end
                    end else if (start_if) begin
                        state_q    <= READ;
                        if_pend_q  <= 1'b0;
                        base_q     <= if_addr_q;
                        len_q      <= 3'd4;
                        is_fetch_q <= 1'b1;
                        cnt_q      <= 3'd0;
                        rbuf_q     <= 32'd0;
                        ram_addr_q <= if_addr_q;
                    end
                end

                READ: begin
                    if (in_rollback) begin
                        state_q <= IDLE;
                    end else if (cnt_q == len_q) begin
                        // rbuf_q was cleared at start, so short loads are already zero-extended.
                        state_q <= IDLE;
                        if (is_fetch_q) begin
                            if_ready_q <= 1'b1;
                            if_inst_q  <= rbuf_q;
                        end else begin
                            ls_ready_q <= 1'b1;
                            ls_rdata_q <= rbuf_q;
                        end
                    end else begin
                        rbuf_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.in_ram_din;
                        cnt_q <= cnt_d;
                        if (cnt_d != len_q) begin
                            ram_addr_q <= addr_d;
                        end
                    end
                end

                WRITE: begin
                    if (cnt_d == len_q) begin
                        state_q    <= IDLE;
                        ram_wr_q   <= 1'b0;
                        ls_ready_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_d;
                        ram_addr_q <= addr_d;
                        ram_dout_q <= wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    ram_wr_q <= 1'b0;
                end
            endcase

            // A new pulse wins over the pending-clear of a transfer starting on the same edge.
            if (take_if) begin
                if_pend_q <= 1'b1;
                if_addr_q <= bus.in_if_addr;
            end
            if (take_ls) begin
                ls_pend_q  <= 1'b1;
                ls_write_q <= bus.in_ls_write;
                ls_addr_q  <= bus.in_ls_addr;
                ls_size_q  <= bus.in_ls_size;
                ls_wdata_q <= bus.in_ls_wdata;
            end
        end
    end

    assign bus.out_if_ready = if_ready_q;
    assign bus.out_if_inst  = if_inst_q;
    assign bus.out_ls_ready = ls_ready_q;
    assign bus.out_ls_rdata = ls_rdata_q;
    assign bus.out_ram_addr = ram_addr_q;
    assign bus.out_ram_dout = ram_dout_q;
    // The write strobe is gated so a stall never repeats a write into the RAM.
    assign bus.out_ram_wr   = ram_wr_q & ena;
    assign dbg_state_o      = state_q;

endmodule
